// File: rtl/arch_io_pkg.sv
// Shared definitions for the board I/O front end: FSM state encoding and
// default debounce timing.
package arch_io_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam int         TICK_BIT_DEF = 17;
  localparam int         DEPTH_DEF    = 4;
  localparam logic [1:0] SETTLE_MAX   = 2'd3;

endpackage

// File: rtl/btn_debounce_cell.sv
// One debounced button: shifts the synchronized input on each sample tick and
// accepts a new level only after DEPTH equal samples.
module btn_debounce_cell
  import arch_io_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic press
);

  logic [DEPTH-1:0] shreg;

  // Press fires only on the 0->1 acceptance; a release just clears the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (tick) begin
        shreg <= {shreg[DEPTH-2:0], din};
      end
      if ((&shreg) && !level) begin
        level <= 1'b1;
        press <= 1'b1;
      end else if (shreg == '0) begin
        level <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/btn_step_ctrl.sv
// Button debounce plus run/single-step clock-enable generation for the CPU.
//   state   | meaning
//   HALT    | CPU stopped, waiting for run mode or a step press
//   RUN     | CPU enabled every cycle
//   STEP    | CPU enabled for exactly one cycle
module btn_step_ctrl
  import arch_io_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int TICK_BIT = TICK_BIT_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int STEP_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      clkdiv,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             sw_step,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             cpu_en,
  output logic             mode_step
);

  logic             tick_prev;
  logic             tick;
  logic [N_BTN-1:0] btn_m;
  logic [N_BTN-1:0] btn_s;
  logic             sw_m;
  logic             sw_s;
  logic [1:0]       settle;
  logic             settled;
  state_t           state;
  state_t           state_nxt;
  logic             unused_clkdiv;

  assign unused_clkdiv = ^clkdiv;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_prev <= 1'b0;
      btn_m     <= '0;
      btn_s     <= '0;
      sw_m      <= 1'b0;
      sw_s      <= 1'b0;
      settle    <= 2'd0;
    end else begin
      tick_prev <= clkdiv[TICK_BIT];
      btn_m     <= btn_raw;
      btn_s     <= btn_m;
      sw_m      <= sw_step;
      sw_s      <= sw_m;
      if (settle != SETTLE_MAX) begin
        settle <= settle + 2'd1;
      end
    end
  end

  assign tick    = clkdiv[TICK_BIT] & ~tick_prev;
  // Keeps the FSM in HALT until the synchronizers hold real samples.
  assign settled = (settle == SETTLE_MAX);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_cell #(
      .DEPTH(DEPTH)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .din  (btn_s[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HALT;
    end else begin
      state <= state_nxt;
    end
  end

  // Switching to run outranks a simultaneous step press.
  always_comb begin
    state_nxt = ST_HALT;
    case (state)
      ST_RUN:  state_nxt = sw_s ? ST_HALT : ST_RUN;
      ST_STEP: state_nxt = sw_s ? ST_HALT : ST_RUN;
      default: begin
        if (settled && !sw_s) begin
          state_nxt = ST_RUN;
        end else if (settled && btn_press[STEP_IDX]) begin
          state_nxt = ST_STEP;
        end else begin
          state_nxt = ST_HALT;
        end
      end
    endcase
  end

  always_comb begin
    cpu_en    = 1'b0;
    mode_step = 1'b1;
    case (state)
      ST_RUN: begin
        cpu_en    = 1'b1;
        mode_step = 1'b0;
      end
      ST_STEP: cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Scoreboard bench for btn_step_ctrl: stimulus queues expected press pulses
// and cpu_en pulses, a monitor matches them as the DUT produces them.
module tb_btn_step_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } press_exp_t;

  typedef struct {
    int cyc;
    int len;  // -1: run of unspecified length (> 1)
  } cen_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] clkdiv = '0;
  logic [3:0]  btn_raw;
  logic        sw_step;
  logic [3:0]  btn_level;
  logic [3:0]  btn_press;
  logic        cpu_en;
  logic        mode_step;

  press_exp_t press_q[$];
  cen_exp_t   cen_q[$];
  press_exp_t pe;
  cen_exp_t   cur_cen;
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       cen_d = 1'b0;
  int         cen_start = 0;
  int         k, p, r, a, b, c, f, bad;

  btn_step_ctrl #(
    .N_BTN   (4),
    .TICK_BIT(2),
    .DEPTH   (3),
    .STEP_IDX(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clkdiv   (clkdiv),
    .btn_raw  (btn_raw),
    .sw_step  (sw_step),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .cpu_en   (cpu_en),
    .mode_step(mode_step)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) clkdiv <= clkdiv + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_err++;
    $display("FAIL %s: got %0d with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Edge at which a clean input edge driven at cycle kd is accepted:
  // ticks land on edges 5 mod 8; the first usable one is >= kd+3 (2-FF sync),
  // then two more ticks, then one cycle to register level/press.
  function automatic int press_at(input int kd);
    int t;
    t = kd + 3;
    while (t % 8 != 5) t++;
    return t + 2 * 8 + 1;
  endfunction

  task automatic wait_cyc(input int cc);
    while (cyc < cc) @(negedge clk);
  endtask

  task automatic run_cycles(input int n, input logic exp_ms, inout int nbad);
    repeat (n) begin
      @(negedge clk);
      if (mode_step !== exp_ms) nbad++;
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (btn_press != 4'b0000) begin
      if (press_q.size() == 0) begin
        unexpected("press_unexpected", {28'd0, btn_press});
      end else begin
        pe = press_q.pop_front();
        check("press_vec", {28'd0, btn_press}, {28'd0, pe.vec});
        check("press_cycle", cyc, pe.cyc);
      end
    end
    if ((cpu_en === 1'b1) && !cen_d) begin
      cen_start = cyc;
      if (cen_q.size() == 0) begin
        unexpected("cen_rise_unexpected", cyc);
        cur_cen.cyc = cyc;
        cur_cen.len = -1;
      end else begin
        cur_cen = cen_q.pop_front();
        check("cen_rise_cycle", cyc, cur_cen.cyc);
      end
    end
    if ((cpu_en === 1'b0) && cen_d) begin
      if (cur_cen.len > 0) check("cen_pulse_len", cyc - cen_start, cur_cen.len);
      else check("cen_run_len_gt1", {31'd0, (cyc - cen_start) > 1}, 1);
    end
    cen_d = (cpu_en === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench stalled at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    btn_raw = 4'b0000;
    sw_step = 1'b0;

    // 1: reset release into run mode
    wait_cyc(5);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_mode_step", mode_step, 1);
    check("rst_btn_level", {28'd0, btn_level}, 0);
    check("rst_btn_press", {28'd0, btn_press}, 0);
    rst = 1'b0;
    r = cyc;
    cen_q.push_back('{cyc: r + 4, len: -1});
    wait_cyc(r + 3);
    check("settle_cpu_en_low", cpu_en, 0);
    check("settle_mode_step", mode_step, 1);
    wait_cyc(r + 4);
    check("run_mode_step", mode_step, 0);

    // 2: clean press and release on button 1
    wait_cyc(r + 20);
    k = cyc;
    btn_raw[1] = 1'b1;
    press_q.push_back('{cyc: press_at(k), vec: 4'b0010});
    wait_cyc(k + 100);
    check("btn1_level_high", btn_level[1], 1);
    btn_raw[1] = 1'b0;
    f = press_at(cyc);
    wait_cyc(f - 1);
    check("btn1_level_before_release", btn_level[1], 1);
    wait_cyc(f);
    check("btn1_level_released", btn_level[1], 0);

    // 3: bouncing button 2, then a steady hold (start phase 1 mod 8)
    wait_cyc(cyc + 10);
    while (cyc % 8 != 1) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      btn_raw[2] = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    btn_raw[2] = 1'b1;
    k = cyc;
    press_q.push_back('{cyc: press_at(k), vec: 4'b0100});
    wait_cyc(press_at(k) + 2);
    check("btn2_level_high", btn_level[2], 1);
    btn_raw[2] = 1'b0;
    wait_cyc(cyc + 40);

    // 4: single-step mode, three step presses
    a = cyc;
    sw_step = 1'b1;
    wait_cyc(a + 4);
    check("halt_cpu_en", cpu_en, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      k = cyc;
      btn_raw[0] = 1'b1;
      press_q.push_back('{cyc: press_at(k), vec: 4'b0001});
      cen_q.push_back('{cyc: press_at(k) + 1, len: 1});
      run_cycles(40, 1'b1, bad);
      btn_raw[0] = 1'b0;
      run_cycles(40, 1'b1, bad);
    end
    check("step_mode_step_held", bad, 0);

    // 5: step press in run mode is ignored
    b = cyc;
    sw_step = 1'b0;
    cen_q.push_back('{cyc: b + 3, len: -1});
    wait_cyc(b + 10);
    btn_raw[0] = 1'b1;
    press_q.push_back('{cyc: press_at(b + 10), vec: 4'b0001});
    bad = 0;
    run_cycles(40, 1'b0, bad);
    btn_raw[0] = 1'b0;
    run_cycles(40, 1'b0, bad);
    check("run_ignores_step", bad, 0);

    // 5b: press coincident with switch to run: run wins
    c = cyc;
    sw_step = 1'b1;
    wait_cyc(c + 10);
    k = cyc;
    btn_raw[0] = 1'b1;
    p = press_at(k);
    press_q.push_back('{cyc: p, vec: 4'b0001});
    cen_q.push_back('{cyc: p + 1, len: -1});
    wait_cyc(p - 2);
    sw_step = 1'b0;
    wait_cyc(p + 1);
    check("coincide_mode_step", mode_step, 0);
    check("coincide_cpu_en", cpu_en, 1);
    wait_cyc(p + 10);
    btn_raw[0] = 1'b0;
    wait_cyc(p + 60);

    // 6: reset during STEP with button 3 held
    c = cyc;
    sw_step = 1'b1;
    wait_cyc(c + 10);
    k = cyc;
    btn_raw[0] = 1'b1;
    p = press_at(k);
    press_q.push_back('{cyc: p, vec: 4'b0001});
    cen_q.push_back('{cyc: p + 1, len: 1});
    wait_cyc(p);
    btn_raw = 4'b1000;
    wait_cyc(p + 1);
    check("step_cycle_cpu_en", cpu_en, 1);
    check("step_cycle_mode_step", mode_step, 1);
    rst = 1'b1;
    wait_cyc(p + 2);
    check("midstep_rst_cpu_en", cpu_en, 0);
    check("midstep_rst_mode_step", mode_step, 1);
    check("midstep_rst_level", {28'd0, btn_level}, 0);
    check("midstep_rst_press", {28'd0, btn_press}, 0);
    wait_cyc(p + 5);
    rst = 1'b0;
    r = cyc;
    press_q.push_back('{cyc: press_at(r), vec: 4'b1000});
    wait_cyc(press_at(r) + 2);
    check("btn3_level_after_rst", {28'd0, btn_level}, 4'b1000);
    check("halt_after_rst_cpu_en", cpu_en, 0);
    btn_raw = 4'b0000;
    wait_cyc(cyc + 60);

    check("press_queue_drained", press_q.size(), 0);
    check("cen_queue_drained", cen_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
